// File: rtl/conv_stream_driver.sv
// rtl/conv_stream_driver.sv - FIFO-fed x transmitter and y receiver that drives one conv block frame by frame
// Optional saturating per-frame result sum on frame_sum, enabled by CONV_DRIVER_SUM_EN.
module conv_stream_driver #(
    parameter int T      = 16,
    parameter int SIZE_X = 96,
    parameter int SIZE_F = 65,
    parameter int DEPTH  = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [T-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [T-1:0] x_data,
    output logic         x_valid,
    input  logic         x_ready,
    input  logic [T-1:0] y_data,
    input  logic         y_valid,
    output logic         y_ready,
    output logic [T-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         frame_done,
`ifdef CONV_DRIVER_SUM_EN
    output logic [T-1:0] frame_sum,
`endif
    output logic [15:0]  frame_count
);
    localparam int CONV_POINTS = SIZE_X - SIZE_F + 1;
    localparam int AW = $clog2(DEPTH);
    localparam int XW = $clog2(SIZE_X + 1);
    localparam int YW = $clog2(CONV_POINTS + 1);
    localparam logic [XW-1:0] X_LAST = XW'(SIZE_X - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(CONV_POINTS - 1);
    localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {SEND = 2'd0, COLLECT = 2'd1, DONE = 2'd2} state_t;
    state_t state, state_nx;

    logic [T-1:0]  mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          empty, full, push, pop, y_fire;
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = x_valid && x_ready;
    assign y_fire   = y_valid && y_ready;
    assign x_data   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= in_data;
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= SEND;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            SEND:    if (pop && x_cnt == X_LAST) state_nx = COLLECT;
            COLLECT: if (y_fire && y_cnt == Y_LAST) state_nx = DONE;
            DONE:    state_nx = SEND;
            default: state_nx = SEND;
        endcase
    end

    always_comb begin
        x_valid    = 1'b0;
        y_ready    = 1'b0;
        frame_done = 1'b0;
        case (state)
            SEND:    x_valid = !empty;
            COLLECT: y_ready = !out_valid || out_ready;
            DONE:    frame_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_cnt       <= '0;
            y_cnt       <= '0;
            frame_count <= '0;
        end else begin
            if (pop)    x_cnt <= (x_cnt == X_LAST) ? '0 : x_cnt + XW'(1);
            if (y_fire) y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + YW'(1);
            if (state == DONE) frame_count <= frame_count + 16'd1;
        end
    end

    // One-entry skid: reload wins over drain so back-to-back words stream at full rate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (y_fire) begin
            out_data  <= y_data;
            out_valid <= 1'b1;
            out_last  <= (y_cnt == Y_LAST);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

`ifdef CONV_DRIVER_SUM_EN
    localparam logic [T-1:0] SUM_MAX = {1'b0, {(T-1){1'b1}}};
    localparam logic [T-1:0] SUM_MIN = {1'b1, {(T-1){1'b0}}};
    logic [T:0] sum_wide;

    assign sum_wide = {frame_sum[T-1], frame_sum} + {y_data[T-1], y_data};

    // Sum is held through DONE and cleared only when the next frame actually starts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_sum <= '0;
        end else if (pop && x_cnt == '0) begin
            frame_sum <= '0;
        end else if (y_fire) begin
            if (sum_wide[T] != sum_wide[T-1]) frame_sum <= sum_wide[T] ? SUM_MIN : SUM_MAX;
            else                              frame_sum <= sum_wide[T-1:0];
        end
    end
`endif
endmodule

// File: tb/tb_conv_stream_driver.sv
// tb/tb_conv_stream_driver.sv - Randomised self-checking bench for conv_stream_driver against a frame-level model
module tb_conv_stream_driver;
    localparam int T      = 16;
    localparam int SIZE_X = 96;
    localparam int SIZE_F = 65;
    localparam int DEPTH  = 16;
    localparam int CP     = SIZE_X - SIZE_F + 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [T-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [T-1:0] x_data;
    logic         x_valid;
    logic         x_ready = 1'b0;
    logic [T-1:0] y_data = '0;
    logic         y_valid = 1'b0;
    logic         y_ready;
    logic [T-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         out_last;
    logic         frame_done;
    logic [15:0]  frame_count;
`ifdef CONV_DRIVER_SUM_EN
    logic [T-1:0] frame_sum;
`endif

    always #5 clk = ~clk;

    conv_stream_driver #(.T(T), .SIZE_X(SIZE_X), .SIZE_F(SIZE_F), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
        .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .frame_done(frame_done),
`ifdef CONV_DRIVER_SUM_EN
        .frame_sum(frame_sum),
`endif
        .frame_count(frame_count)
    );

    int checks = 0;
    int errors = 0;

    logic [T-1:0] up_q[$], res_q[$], pushed_q[$], sent_q[$], obs_x[$], obs_out[$], obs_sum[$];
    bit           obs_last[$];
    int           y_cyc[$];
    int n_x, n_y, n_done, conv_rx, conv_left, cyc;
    int p_in, p_xr, p_yv, p_or;
    int collect_viol, xstab_viol, ostab_viol, in_low, y_ready_seen, out_valid_seen;
    bit in_fired, y_fired, prev_xv, prev_xr, prev_ov, prev_or;
    logic [T-1:0] prev_xd, prev_od;

    function automatic bit chance(int pct);
        return $urandom_range(99) < pct;
    endfunction

    // Environment: upstream source, conv model (consumes SIZE_X, returns CP) and downstream sink.
    task automatic tick();
        if (!in_valid && up_q.size() > 0 && chance(p_in)) begin
            in_valid = 1'b1;
            in_data  = up_q.pop_front();
        end
        x_ready = chance(p_xr);
        if (!y_valid && conv_left > 0 && chance(p_yv)) begin
            y_valid = 1'b1;
            y_data  = res_q.pop_front();
            sent_q.push_back(y_data);
            conv_left--;
        end
        out_ready = chance(p_or);
        @(negedge clk);
        in_fired = in_valid && in_ready;
        y_fired  = y_valid && y_ready;
        if (in_fired) pushed_q.push_back(in_data);
        if (!in_ready) in_low++;
        if (y_ready) y_ready_seen++;
        if (out_valid) out_valid_seen++;
        if (x_valid && conv_rx >= SIZE_X) collect_viol++;
        if (prev_xv && !prev_xr && (!x_valid || x_data !== prev_xd)) xstab_viol++;
        if (prev_ov && !prev_or && (!out_valid || out_data !== prev_od)) ostab_viol++;
        if (x_valid && x_ready) begin
            obs_x.push_back(x_data);
            n_x++;
            conv_rx++;
            if (conv_rx == SIZE_X) begin
                conv_left = CP;
                while (res_q.size() < CP) res_q.push_back(T'($urandom));
            end
        end
        if (y_fired) begin
            n_y++;
            y_cyc.push_back(cyc);
        end
        if (out_valid && out_ready) begin
            obs_out.push_back(out_data);
            obs_last.push_back(out_last);
        end
        if (frame_done) begin
            n_done++;
            conv_rx = 0;
`ifdef CONV_DRIVER_SUM_EN
            obs_sum.push_back(frame_sum);
`endif
        end
        prev_xv = x_valid; prev_xr = x_ready; prev_xd = x_data;
        prev_ov = out_valid; prev_or = out_ready; prev_od = out_data;
        cyc++;
        @(posedge clk);
        #1;
        if (in_fired) in_valid = 1'b0;
        if (y_fired) y_valid = 1'b0;
    endtask

    function automatic bit reached(int kind, int target, int c);
        case (kind)
            0:       return c >= target;
            1:       return n_x >= target;
            2:       return n_done >= target;
            default: return pushed_q.size() >= target;
        endcase
    endfunction

    task automatic run(input int kind, input int target, input int budget, output bit ok);
        int c = 0;
        while (!reached(kind, target, c) && c < budget) begin
            tick();
            c++;
        end
        ok = reached(kind, target, c);
    endtask

    function automatic int x_errs();
        int bad = 0;
        if (obs_x.size() > pushed_q.size()) bad++;
        for (int i = 0; i < obs_x.size(); i++)
            if (i >= pushed_q.size() || obs_x[i] !== pushed_q[i]) bad++;
        return bad;
    endfunction

    function automatic int out_errs();
        int bad = 0;
        if (obs_out.size() != sent_q.size()) bad++;
        for (int i = 0; i < obs_out.size(); i++) begin
            if (i >= sent_q.size() || obs_out[i] !== sent_q[i]) bad++;
            if (obs_last[i] !== ((i % CP) == CP - 1)) bad++;
        end
        return bad;
    endfunction

    function automatic int sum_errs();
        int bad = 0;
        int s;
        for (int f = 0; f < obs_sum.size(); f++) begin
            s = 0;
            for (int j = 0; j < CP; j++) begin
                s = s + int'($signed(sent_q[f*CP+j]));
                if (s > (2**(T-1)) - 1) s = (2**(T-1)) - 1;
                else if (s < -(2**(T-1))) s = -(2**(T-1));
            end
            if (obs_sum[f] !== T'(s)) bad++;
        end
        return bad;
    endfunction

    task automatic apply_reset();
        reset = 1'b0;
        in_valid = 1'b0; y_valid = 1'b0; x_ready = 1'b0; out_ready = 1'b0;
        in_data = '0; y_data = '0;
        up_q.delete(); res_q.delete(); pushed_q.delete(); sent_q.delete();
        obs_x.delete(); obs_out.delete(); obs_last.delete(); obs_sum.delete(); y_cyc.delete();
        n_x = 0; n_y = 0; n_done = 0; conv_rx = 0; conv_left = 0;
        collect_viol = 0; xstab_viol = 0; ostab_viol = 0; in_low = 0;
        prev_xv = 1'b0; prev_ov = 1'b0;
        #2;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        apply_reset();
        checks++;
        if ({in_ready, x_valid, y_ready, out_valid, out_last, frame_done} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 100000", {in_ready, x_valid, y_ready, out_valid, out_last, frame_done});
        end
        checks++;
        if (frame_count !== 16'd0 || x_data !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_values: frame_count=%0d x_data=%h out_data=%h want 0", frame_count, x_data, out_data);
        end
`ifdef CONV_DRIVER_SUM_EN
        checks++;
        if (frame_sum !== '0) begin errors++; $display("FAIL reset_sum: got %h want 0", frame_sum); end
`endif
        release_reset();
    endtask

    task automatic test_first_frame();
        bit ok;
        int bad;
        for (int i = 1; i <= 100; i++) up_q.push_back(T'(i));
        for (int i = 10; i <= 41; i++) res_q.push_back(T'(i));
        p_in = 100; p_xr = 100; p_yv = 100; p_or = 100;
        run(1, SIZE_X, 400, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL first_x_timeout: x transfers %0d want %0d", n_x, SIZE_X); end
        bad = 0;
        for (int i = 0; i < SIZE_X; i++) if (i >= obs_x.size() || obs_x[i] !== T'(i + 1)) bad++;
        checks++;
        if (bad != 0 || obs_x.size() != SIZE_X) begin
            errors++; $display("FAIL first_x_order: %0d bad of %0d sent, want 0 bad of %0d", bad, obs_x.size(), SIZE_X);
        end
        checks++;
        if (x_valid !== 1'b0 || pushed_q.size() <= n_x) begin
            errors++; $display("FAIL first_x_valid_after_last: x_valid=%b pushed=%0d sent=%0d want x_valid 0 with data queued", x_valid, pushed_q.size(), n_x);
        end
        run(2, 1, 300, ok);
        run(0, 3, 3, ok);
        bad = 0;
        for (int i = 0; i < CP; i++)
            if (i >= obs_out.size() || obs_out[i] !== T'(10 + i) || obs_last[i] !== (i == CP - 1)) bad++;
        checks++;
        if (bad != 0 || obs_out.size() != CP) begin
            errors++; $display("FAIL first_out: %0d bad of %0d words, want 0 bad of %0d", bad, obs_out.size(), CP);
        end
        checks++;
        if (n_done != 1 || frame_count !== 16'd1) begin
            errors++; $display("FAIL first_done: pulses=%0d frame_count=%0d want 1/1", n_done, frame_count);
        end
        checks++;
        if (in_low != 0 || collect_viol != 0) begin
            errors++; $display("FAIL first_flow: in_ready low %0d cycles, x_valid in collect %0d, want 0/0", in_low, collect_viol);
        end
    endtask

    task automatic test_out_backpressure();
        bit ok;
        int ny0;
        for (int i = 0; i < SIZE_X - 4; i++) up_q.push_back(T'($urandom));
        p_or = 0;
        run(1, 2 * SIZE_X, 600, ok);
        ny0 = n_y;
        run(0, 12, 12, ok);
        checks++;
        if (n_y - ny0 != 1 || y_ready !== 1'b0) begin
            errors++; $display("FAIL bp_y_stall: accepted %0d y_ready=%b want 1 accepted, y_ready 0", n_y - ny0, y_ready);
        end
        checks++;
        if (out_valid !== 1'b1 || sent_q.size() <= CP || out_data !== sent_q[CP]) begin
            errors++; $display("FAIL bp_out_held: out_valid=%b out_data=%h want held first result of frame 2", out_valid, out_data);
        end
        p_or = 50; p_yv = 70;
        run(2, 2, 1500, ok);
        p_or = 100;
        run(0, 4, 4, ok);
        checks++;
        if (!ok || out_errs() != 0 || ostab_viol != 0 || frame_count !== 16'd2) begin
            errors++; $display("FAIL bp_drain: out errs %0d unstable %0d frame_count=%0d want 0/0/2", out_errs(), ostab_viol, frame_count);
        end
    endtask

    task automatic test_y_in_send();
        bit ok;
        int yr0 = y_ready_seen;
        int ov0 = out_valid_seen;
        y_valid = 1'b1;
        y_data  = T'($urandom);
        run(0, 6, 6, ok);
        y_valid = 1'b0;
        checks++;
        if (y_ready_seen != yr0 || out_valid_seen != ov0) begin
            errors++; $display("FAIL y_in_send: y_ready high %0d cycles, out_valid high %0d cycles, want 0/0", y_ready_seen - yr0, out_valid_seen - ov0);
        end
    endtask

    task automatic test_fifo_full();
        bit ok;
        int base;
        p_xr = 0; p_in = 100;
        for (int i = 0; i < 20; i++) up_q.push_back(T'($urandom));
        base = pushed_q.size();
        run(3, base + 1, 10, ok);
        checks++;
        if (!ok || x_valid !== 1'b1 || x_data !== pushed_q[base]) begin
            errors++; $display("FAIL in_to_x_latency: x_valid=%b x_data=%h want 1 and first pushed word", x_valid, x_data);
        end
        run(0, 30, 30, ok);
        checks++;
        if (pushed_q.size() - base != DEPTH || in_ready !== 1'b0) begin
            errors++; $display("FAIL fifo_full: pushes=%0d in_ready=%b want %0d and 0", pushed_q.size() - base, in_ready, DEPTH);
        end
        p_xr = 100;
        run(1, n_x + DEPTH, 100, ok);
        checks++;
        if (!ok || x_errs() != 0 || xstab_viol != 0) begin
            errors++; $display("FAIL fifo_order: x errs %0d unstable %0d want 0/0", x_errs(), xstab_viol);
        end
        for (int i = 0; i < SIZE_X - 20; i++) up_q.push_back(T'($urandom));
        p_in = 70; p_xr = 70; p_yv = 70; p_or = 70;
        run(2, 3, 3000, ok);
        p_or = 100;
        run(0, 4, 4, ok);
        checks++;
        if (x_errs() != 0 || out_errs() != 0 || frame_count !== 16'd3) begin
            errors++; $display("FAIL fifo_frame: x errs %0d out errs %0d frame_count=%0d want 0/0/3", x_errs(), out_errs(), frame_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        p_in = 80; p_xr = 80; p_yv = 80; p_or = 80;
        for (int i = 0; i < SIZE_X; i++) up_q.push_back(T'($urandom));
        run(1, n_x + 50, 500, ok);
        apply_reset();
        checks++;
        if (!ok || x_valid !== 1'b0 || in_ready !== 1'b1 || frame_count !== 16'd0) begin
            errors++; $display("FAIL mid_reset: x_valid=%b in_ready=%b frame_count=%0d want 0/1/0", x_valid, in_ready, frame_count);
        end
        release_reset();
        p_in = 0;
        run(0, 3, 3, ok);
        checks++;
        if (x_valid !== 1'b0 || n_done != 0) begin
            errors++; $display("FAIL mid_reset_empty: x_valid=%b done pulses=%0d want 0/0", x_valid, n_done);
        end
        p_in = 80;
        for (int i = 0; i < SIZE_X; i++) up_q.push_back(T'($urandom));
        run(2, 1, 2000, ok);
        p_or = 100;
        run(0, 4, 4, ok);
        checks++;
        if (!ok || obs_x.size() != SIZE_X || x_errs() != 0 || out_errs() != 0 || frame_count !== 16'd1) begin
            errors++; $display("FAIL mid_reset_next: sent %0d x errs %0d out errs %0d frame_count=%0d want %0d/0/0/1", obs_x.size(), x_errs(), out_errs(), frame_count, SIZE_X);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int y0 = y_cyc.size();
        p_in = 100; p_xr = 100; p_yv = 100; p_or = 100;
        for (int i = 0; i < SIZE_X; i++) up_q.push_back(T'($urandom));
        run(2, n_done + 1, 500, ok);
        checks++;
        if (!ok || y_cyc.size() < y0 + CP || y_cyc[y0 + CP - 1] - y_cyc[y0] != CP - 1) begin
            errors++; $display("FAIL throughput: %0d results spanned %0d cycles want %0d", y_cyc.size() - y0, (y_cyc.size() >= y0 + CP) ? y_cyc[y0 + CP - 1] - y_cyc[y0] + 1 : -1, CP);
        end
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < SIZE_X; i++) up_q.push_back(T'($urandom));
            for (int i = 0; i < CP; i++) res_q.push_back(T'($urandom));
        end
        p_in = $urandom_range(100, 30); p_xr = $urandom_range(100, 30);
        p_yv = $urandom_range(100, 30); p_or = $urandom_range(100, 30);
        run(2, n_done + 3, 20000, ok);
        p_or = 100;
        run(0, 4, 4, ok);
        checks++;
        if (!ok || x_errs() != 0 || out_errs() != 0 || frame_count !== 16'd5) begin
            errors++; $display("FAIL b2b: x errs %0d out errs %0d frame_count=%0d want 0/0/5", x_errs(), out_errs(), frame_count);
        end
`ifdef CONV_DRIVER_SUM_EN
        checks++;
        if (sum_errs() != 0) begin errors++; $display("FAIL b2b_sum: %0d frame sums wrong, want 0", sum_errs()); end
`endif
    endtask

`ifdef CONV_DRIVER_SUM_EN
    task automatic test_sum();
        bit ok;
        p_in = 100; p_xr = 100; p_yv = 100; p_or = 100;
        for (int i = 0; i < CP; i++) res_q.push_back(16'h7000);
        for (int i = 0; i < SIZE_X; i++) up_q.push_back(T'($urandom));
        run(2, n_done + 1, 500, ok);
        checks++;
        if (!ok || obs_sum.size() == 0 || obs_sum[obs_sum.size() - 1] !== 16'h7FFF) begin
            errors++; $display("FAIL sum_pos_sat: got %h want 7fff", (obs_sum.size() > 0) ? obs_sum[obs_sum.size() - 1] : 16'hxxxx);
        end
        for (int i = 0; i < CP; i++) res_q.push_back(16'h9000);
        for (int i = 0; i < SIZE_X; i++) up_q.push_back(T'($urandom));
        run(2, n_done + 1, 500, ok);
        checks++;
        if (!ok || obs_sum.size() == 0 || obs_sum[obs_sum.size() - 1] !== 16'h8000) begin
            errors++; $display("FAIL sum_neg_sat: got %h want 8000", (obs_sum.size() > 0) ? obs_sum[obs_sum.size() - 1] : 16'hxxxx);
        end
        checks++;
        if (sum_errs() != 0) begin errors++; $display("FAIL sum_model: %0d frame sums wrong, want 0", sum_errs()); end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_first_frame();
        test_out_backpressure();
        test_y_in_send();
        test_fifo_full();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef CONV_DRIVER_SUM_EN
        test_sum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
